// File: rtl/axil_sram_responder.sv
// AXI4-Lite memory-side responder: word-addressed SRAM mapped at BASE with
// independent read and write channels and a programmable response latency.
module axil_sram_responder #(
    parameter int unsigned         ADDR_W     = 32,
    parameter int unsigned         DATA_W     = 32,
    parameter int unsigned         DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0]   BASE       = ADDR_W'(32'h8000_0000),
    parameter int unsigned         LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OFF_HI = DEPTH_LOG2 + 2;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Address decode for both channels
    logic [ADDR_W-1:0]     ar_off, aw_off;
    logic                  ar_hit, aw_hit;
    logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
    logic                  unused_ok;

    assign ar_off    = araddr - BASE;
    assign aw_off    = awaddr - BASE;
    assign ar_hit    = (araddr >= BASE) && (ar_off[ADDR_W-1:OFF_HI] == '0);
    assign aw_hit    = (awaddr >= BASE) && (aw_off[ADDR_W-1:OFF_HI] == '0);
    assign ar_idx    = ar_off[OFF_HI-1:2];
    assign aw_idx    = aw_off[OFF_HI-1:2];
    assign unused_ok = ^{ar_off[1:0], aw_off[1:0]};

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx_q, rd_idx;
    logic                  r_hit_q, rd_hit, r_enter;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        unique case (r_state)
            R_IDLE:  if (arvalid) r_state_next = (LAT == 0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_cnt == CNT_W'(1)) r_state_next = R_RESP;
            R_RESP:  if (rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        if (r_state == R_IDLE) arready = 1'b1;
        if (r_state == R_RESP) rvalid  = 1'b1;
    end

    // With zero latency the response is sampled on the handshake edge itself
    assign r_enter = (r_state != R_RESP) && (r_state_next == R_RESP);
    assign rd_idx  = (r_state == R_IDLE) ? ar_idx : r_idx_q;
    assign rd_hit  = (r_state == R_IDLE) ? ar_hit : r_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx_q <= '0;
            r_hit_q <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                r_cnt   <= LAT_C;
                r_idx_q <= ar_idx;
                r_hit_q <= ar_hit;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_enter) begin
                rdata <= rd_hit ? mem[rd_idx] : '0;
                rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_next;
    logic [CNT_W-1:0]      w_cnt;
    logic                  aw_done, w_done, aw_hs, w_hs, aw_have, w_have;
    logic [DEPTH_LOG2-1:0] aw_idx_q, c_idx;
    logic                  aw_hit_q, c_hit, w_enter;
    logic [DATA_W-1:0]     wdata_q, c_data, c_mask;
    logic [STRB_W-1:0]     wstrb_q, c_strb;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_have = aw_done || aw_hs;
    assign w_have  = w_done || w_hs;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_have && w_have) w_state_next = (LAT == 0) ? W_RESP : W_WAIT;
            W_WAIT:  if (w_cnt == CNT_W'(1)) w_state_next = W_RESP;
            W_RESP:  if (bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        if (w_state == W_IDLE) begin
            awready = !aw_done;
            wready  = !w_done;
        end
        if (w_state == W_RESP) bvalid = 1'b1;
    end

    // Commit operands: captured copy if already accepted, else the live bus
    assign w_enter = (w_state != W_RESP) && (w_state_next == W_RESP);
    assign c_idx   = aw_done ? aw_idx_q : aw_idx;
    assign c_hit   = aw_done ? aw_hit_q : aw_hit;
    assign c_data  = w_done ? wdata_q : wdata;
    assign c_strb  = w_done ? wstrb_q : wstrb;

    for (genvar b = 0; b < STRB_W; b++) begin : g_mask
        assign c_mask[b*8 +: 8] = {8{c_strb[b]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_idx_q <= '0;
            aw_hit_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            w_cnt    <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            if (w_state == W_RESP && bready) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done  <= 1'b1;
                    aw_idx_q <= aw_idx;
                    aw_hit_q <= aw_hit;
                end
                if (w_hs) begin
                    w_done  <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
            end
            if (w_state == W_IDLE && aw_have && w_have) w_cnt <= LAT_C;
            else if (w_state == W_WAIT)                 w_cnt <= w_cnt - CNT_W'(1);
            if (w_enter) bresp <= c_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    // SRAM array is not reset; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && w_enter && c_hit)
            mem[c_idx] <= (mem[c_idx] & ~c_mask) | (c_data & c_mask);
    end
endmodule
